conv_pixel_engine: RTL and testbench
====================================

Name: conv_pixel_engine

Overview:
- Computes one output pixel for NUM_CH output channels in parallel.
- Per channel: streams MAC beats, adds a per-channel bias, applies LeakyReLU, then requantizes to INT8.
- Replaces the per-channel, one-MAC-at-a-time mac_int8 → leaky_relu → requantize chain.
- Each beat is one shared activation plus NUM_CH weights. Result is a packed INT8 vector on a valid/ready output.

Parameters:
- NUM_CH, 4, output channels computed in parallel.
- MAX_MACS, 4608, maximum MAC beats per pixel; sets the counter width CW = $clog2(MAX_MACS+1).
- ACC_W, 32, accumulator width per channel.
- SCALE_Q, 16, fractional bits of the requantize scale.
- LEAKY_MUL, 13, negative-slope multiplier.
- LEAKY_SHIFT, 7, negative-slope shift; slope = 13/128.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a pixel; sampled only in IDLE.
- num_macs  in  CW  beat count for this pixel; latched on start.
- scale  in  16  unsigned requantize scale; latched on start.
- bias  in  NUM_CH*32  signed per-channel bias, channel c at [32c+31:32c]; latched on start.
- in_valid  in  1  MAC beat valid.
- in_ready  out  1  engine accepts a beat.
- act  in  8  signed shared activation.
- wt  in  NUM_CH*8  signed weights, channel c at [8c+7:8c].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  NUM_CH*8  signed INT8 results, channel c at [8c+7:8c].
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the output handshake.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE.
  - in_ready, out_valid, busy, done = 0.
  - out_data = 0, accumulators = 0, beat counter = 0.
  - Reset mid-pixel discards all work; no output is produced.
- States: IDLE, ACCUM, BIAS, ACT, QUANT, OUT.
- IDLE:
  - On start=1: latch num_macs, scale and bias; clear accumulators and counter.
  - Next state is ACCUM, or BIAS when num_macs==0.
  - start is ignored in every other state.
- ACCUM:
  - in_ready=1.
  - Each in_valid&&in_ready beat: acc[c] += sext(wt[c])*sext(act) for every c (16-bit product, sign-extended), and the counter increments.
  - When the beat that brings counter to num_macs is accepted, next state is BIAS.
  - Gaps in in_valid are allowed; the accumulators hold while in_valid is low.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
- BIAS (1 cycle): acc[c] += bias[c], modulo 2^ACC_W.
- ACT (1 cycle):
  - acc[c] >= 0: y = acc[c].
  - acc[c] < 0: y = (acc[c]*LEAKY_MUL) >>> LEAKY_SHIFT, computed in ACC_W+8 bits, arithmetic shift (floor), truncated back to ACC_W.
- QUANT (1 cycle):
  - p = y*scale, signed ACC_W × unsigned 16 → ACC_W+17 bits.
  - r = (p + 2^(SCALE_Q-1)) >>> SCALE_Q.
  - Saturate r to [-128,127] and register it into out_data.
  - Next state OUT.
- OUT:
  - out_valid=1; out_data holds stable until out_valid&&out_ready.
  - On that handshake: done=1 for that cycle (registered, asserted the cycle after), out_valid drops, next state IDLE.
  - out_data keeps its last value after the handshake.
- Latency: out_valid rises exactly 3 cycles after the clock edge accepting the final beat; 3 cycles after start when num_macs==0.
- Throughput: one beat per cycle in ACCUM. A new start is accepted the cycle after done is asserted.
- num_macs > MAX_MACS is unsupported; the counter is sized for MAX_MACS only.

Test Plan:
- Basic: NUM_CH=4, num_macs=288, all wt=1, act=1, bias=0, scale=655, back-to-back beats → out_data all 3; out_valid exactly 3 cycles after the last beat; in_ready high for exactly 288 accepted beats.
- Negative leaky: wt=-1, act=2, 288 beats, bias=0, scale=655 → acc=-576, leaky=-59, out=-1 on all channels. Per-channel mix: ch0 bias=+600 → acc=24 → out 0; other channels -1.
- Saturation: scale=65535, wt=act=1, 288 beats → 127. Then wt=127, act=-128, 288 beats → -128, with no wrap in the leaky or quant products.
- Bias-only and backpressure: num_macs=0, bias=100, scale=655 → out 1 three cycles after start. Hold out_ready low 5 cycles → out_data and out_valid stable throughout; done pulses once on the handshake.
- Stalls and control: random in_valid gaps (~50%) on the 288-beat basic case → same result 3. start pulsed during ACCUM → ignored. rst_n low mid-ACCUM at beat 100, then a fresh pixel → correct result with no residue; out_valid never asserts for the aborted pixel.

Source files
------------

// File: rtl/conv_pixel_engine.sv
// Multi-channel conv output pixel: MAC stream, bias, LeakyReLU, INT8 requantize.
// One shared activation per beat feeds NUM_CH weight lanes in parallel.
module conv_pixel_engine #(
  parameter int NUM_CH      = 4,
  parameter int MAX_MACS    = 4608,
  parameter int ACC_W       = 32,
  parameter int SCALE_Q     = 16,
  parameter int LEAKY_MUL   = 13,
  parameter int LEAKY_SHIFT = 7,
  localparam int CW         = $clog2(MAX_MACS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CW-1:0]         num_macs,
  input  logic [15:0]           scale,
  input  logic [NUM_CH*32-1:0]  bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            act,
  input  logic [NUM_CH*8-1:0]   wt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_CH*8-1:0]   out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = ACC_W + 17;
  localparam int LW = ACC_W + 8;

  localparam logic signed [LW-1:0] LMUL = LW'(LEAKY_MUL);
  localparam logic [PW-1:0]        RND  = PW'(1) << (SCALE_Q - 1);
  localparam logic signed [PW-1:0] QMAX = PW'(127);
  localparam logic signed [PW-1:0] QMIN = -PW'(128);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    BIAS,
    ACT,
    QUANT,
    OUT
  } state_e;

  state_e                     state_q;
  logic [CW-1:0]              num_q;
  logic [CW-1:0]              cnt_q;
  logic [CW-1:0]              cnt_d;
  logic [15:0]                scale_q;
  logic [NUM_CH*32-1:0]       bias_q;
  logic signed [ACC_W-1:0]    acc_q    [NUM_CH];
  logic signed [ACC_W-1:0]    mac_d    [NUM_CH];
  logic signed [ACC_W-1:0]    bsum_d   [NUM_CH];
  logic signed [ACC_W-1:0]    leaky_d  [NUM_CH];
  logic [NUM_CH*8-1:0]        quant_d;
  logic [NUM_CH*8-1:0]        out_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       beat;

  function automatic logic signed [ACC_W-1:0] mac_term(
    input logic [7:0] w,
    input logic [7:0] a
  );
    logic signed [15:0] p;
    p = $signed(w) * $signed(a);
    return {{(ACC_W-16){p[15]}}, p};
  endfunction

  // Negative slope evaluated wide so the multiply cannot wrap before the shift.
  function automatic logic signed [ACC_W-1:0] leaky(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [LW-1:0] m;
    m = $signed({{8{a[ACC_W-1]}}, a}) * LMUL;
    m = m >>> LEAKY_SHIFT;
    return a[ACC_W-1] ? m[ACC_W-1:0] : a;
  endfunction

  function automatic logic [7:0] requant(
    input logic signed [ACC_W-1:0] y,
    input logic [15:0]             s
  );
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] r;
    p = $signed({{17{y[ACC_W-1]}}, y})
      * $signed({{(ACC_W+1){1'b0}}, s});
    p = p + $signed(RND);
    r = p >>> SCALE_Q;
    if (r > QMAX) begin
      return 8'h7f;
    end else if (r < QMIN) begin
      return 8'h80;
    end
    return r[7:0];
  endfunction

  assign beat  = in_valid && in_ready_q;
  assign cnt_d = cnt_q + CW'(1);

  always_comb begin
    quant_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mac_d[c]   = acc_q[c] + mac_term(wt[8*c +: 8], act);
      bsum_d[c]  = acc_q[c] + ACC_W'($signed(bias_q[32*c +: 32]));
      leaky_d[c] = leaky(acc_q[c]);
      quant_d[8*c +: 8] = requant(acc_q[c], scale_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      cnt_q       <= '0;
      scale_q     <= '0;
      bias_q      <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            num_q   <= num_macs;
            scale_q <= scale;
            bias_q  <= bias;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
              acc_q[c] <= '0;
            end
            if (num_macs == '0) begin
              state_q <= BIAS;
            end else begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            cnt_q <= cnt_d;
            for (int c = 0; c < NUM_CH; c++) begin
              acc_q[c] <= mac_d[c];
            end
            if (cnt_d == num_q) begin
              in_ready_q <= 1'b0;
              state_q    <= BIAS;
            end
          end
        end
        BIAS: begin
          for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c] <= bsum_d[c];
          end
          state_q <= ACT;
        end
        ACT: begin
          for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c] <= leaky_d[c];
          end
          state_q <= QUANT;
        end
        QUANT: begin
          out_q       <= quant_d;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_pixel_engine.sv
// Directed bench for conv_pixel_engine with hand-computed INT8 results.
module tb_conv_pixel_engine;

  localparam int NUM_CH = 4;
  localparam int CW     = $clog2(4608 + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [CW-1:0]        num_macs;
  logic [15:0]          scale;
  logic [NUM_CH*32-1:0] bias;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           act;
  logic [NUM_CH*8-1:0]  wt;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_CH*8-1:0]  out_data;
  logic                 busy;
  logic                 done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_pixel_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_macs  (num_macs),
    .scale     (scale),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act       (act),
    .wt        (wt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pixel(input int n, input logic [15:0] sc,
                             input logic [NUM_CH*32-1:0] b);
    num_macs = CW'(n);
    scale    = sc;
    bias     = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Returns #1 after the edge that accepted the final beat.
  task automatic feed(input int n, input logic [7:0] w, input logic [7:0] a,
                      input bit gaps, input int start_at,
                      output int acc_n, output int rdy_n);
    acc_n = 0;
    rdy_n = 0;
    for (int g = 0; g < 4000 && acc_n < n; g++) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wt       = {NUM_CH{w}};
      act      = a;
      start    = (start_at >= 0 && acc_n == start_at);
      if (start) num_macs = CW'(5);
      if (in_ready) rdy_n++;
      if (in_valid && in_ready) acc_n++;
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (acc_n < n) check("feed_timeout", 64'(acc_n), 64'(n));
  endtask

  task automatic wait_valid(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check(tag, 64'(lat), 64'd3);
  endtask

  task automatic take_out(input string tag, input logic [31:0] exp,
                          input int hold);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(out_data), 64'(exp));
      check({tag, "_hold_done"}, 64'(done), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_busy_drop"}, 64'(busy), 64'd0);
    check({tag, "_data_keep"}, 64'(out_data), 64'(exp));
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int an;
    int rn;
    int seen;
    rst_n     = 1'b0;
    start     = 1'b0;
    num_macs  = '0;
    scale     = '0;
    bias      = '0;
    in_valid  = 1'b0;
    act       = '0;
    wt        = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // 288 * 655 rounds to 3.
    start_pixel(288, 16'd655, '0);
    check("basic_busy", 64'(busy), 64'd1);
    feed(288, 8'h01, 8'h01, 1'b0, -1, an, rn);
    check("basic_accepted", 64'(an), 64'd288);
    check("basic_ready_cycles", 64'(rn), 64'd288);
    check("basic_ready_low", 64'(in_ready), 64'd0);
    wait_valid("basic_latency");
    take_out("basic", 32'h03030303, 0);

    // -576 -> leaky -59 -> -1.
    start_pixel(288, 16'd655, '0);
    feed(288, 8'hff, 8'h02, 1'b0, -1, an, rn);
    wait_valid("neg_latency");
    take_out("neg", 32'hffffffff, 0);

    start_pixel(288, 16'd655, {32'd0, 32'd0, 32'd0, 32'd600});
    feed(288, 8'hff, 8'h02, 1'b0, -1, an, rn);
    wait_valid("mix_latency");
    take_out("mix", 32'hffffff00, 0);

    start_pixel(288, 16'hffff, '0);
    feed(288, 8'h01, 8'h01, 1'b0, -1, an, rn);
    wait_valid("satp_latency");
    take_out("satp", 32'h7f7f7f7f, 0);

    // 127 * -128 * 288 = -4681728; leaky -475488; needs >32-bit product.
    start_pixel(288, 16'hffff, '0);
    feed(288, 8'h7f, 8'h80, 1'b0, -1, an, rn);
    wait_valid("satn_latency");
    take_out("satn", 32'h80808080, 0);

    start_pixel(0, 16'd655, {4{32'd100}});
    check("bias_only_ready", 64'(in_ready), 64'd0);
    wait_valid("bias_only_latency");
    take_out("bias_only", 32'h01010101, 5);

    start_pixel(288, 16'd655, '0);
    feed(288, 8'h01, 8'h01, 1'b1, -1, an, rn);
    check("gaps_accepted", 64'(an), 64'd288);
    wait_valid("gaps_latency");
    take_out("gaps", 32'h03030303, 0);

    start_pixel(288, 16'd655, '0);
    feed(288, 8'h01, 8'h01, 1'b0, 50, an, rn);
    check("restart_accepted", 64'(an), 64'd288);
    wait_valid("restart_latency");
    take_out("restart", 32'h03030303, 0);

    start_pixel(288, 16'd655, {4{32'd5000}});
    feed(100, 8'h7f, 8'h7f, 1'b0, -1, an, rn);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_output", 64'(seen), 64'd0);

    // 576 * 655 rounds to 6; any residue would raise it.
    start_pixel(288, 16'd655, '0);
    feed(288, 8'h02, 8'h01, 1'b0, -1, an, rn);
    wait_valid("fresh_latency");
    take_out("fresh", 32'h06060606, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
